stereolbm_mul_sched: RTL
========================

STEREOLBM_MUL_SCHED -- requirements
Module: stereolbm_mul_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter TAG_W, default 2: width of rsp_tag; clog2(NREQ).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: result FIFO entries; power of two, at least 4.
REQ-004 SHALL have port ap_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1 bit: reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, NREQ bits: per-requester operand valid.
REQ-007 SHALL have port req_ready, output, NREQ bits: per-requester grant; at most one bit high.
REQ-008 SHALL have port req_a, input, NREQ*32 bits: signed 32-bit operand; slice i belongs to requester i.
REQ-009 SHALL have port req_b, input, NREQ*11 bits: unsigned 11-bit operand; slice i belongs to requester i.
REQ-010 SHALL have port rsp_valid, output, 1 bit: result available at FIFO head.
REQ-011 SHALL have port rsp_ready, input, 1 bit: consumer accepts the head result.
REQ-012 SHALL have port rsp_tag, output, TAG_W bits: index of the requester that issued the head result.
REQ-013 SHALL have port rsp_data, output, 32 bits: head product.
REQ-014 SHALL have port busy, output, 1 bit: high when any operation is in flight or the FIFO is non-empty.

Function
REQ-015 SHALL form rsp_data as the low 32 bits of signed(a) x zero-extended(b).
REQ-016 SHALL use a single internal multiplier with one product register, ce held high.
REQ-017 SHALL accept requester i at a rising edge only when req_valid[i] and req_ready[i] are both high in the preceding cycle.
REQ-018 SHALL drive req_ready combinationally as a one-hot grant among the valid requesters, or all-zero when credits = FIFO_DEPTH.
REQ-019 SHALL arbitrate round-robin: the search starts at last_grant+1 modulo NREQ, and last_grant updates only on acceptance.
REQ-020 SHALL register operands and tag at acceptance edge k, register the product at edge k+1, and write it to the FIFO at edge k+2.
REQ-021 SHALL raise rsp_valid no earlier than the cycle after edge k+2, giving a 3-cycle request-to-response minimum.
REQ-022 SHALL keep credits as FIFO occupancy plus in-flight operations (0..2), bounded by FIFO_DEPTH, so no result is ever dropped.
REQ-023 SHALL pop the FIFO when rsp_valid and rsp_ready are both high; on a simultaneous grant and pop, credits are unchanged.
REQ-024 SHALL return results in acceptance order; FIFO read and write pointers wrap modulo FIFO_DEPTH.
REQ-025 SHALL hold rsp_tag and rsp_data stable while rsp_valid is high and rsp_ready is low.
REQ-026 SHALL treat req_valid falling without a handshake as a withdrawn request, with no state change.

Reset
REQ-027 SHALL, while ap_rst_n is low, drive rsp_valid=0, busy=0, and req_ready=0, and clear credits and FIFO pointers.
REQ-028 SHALL set last_grant to NREQ-1 on reset, so requester 0 wins first.
REQ-029 SHALL discard in-flight operations on reset mid-operation, so that none produces a response after release.
REQ-030 SHALL resume granting on the first rising edge after ap_rst_n deasserts.

Configuration
REQ-031 SHALL, with macro STEREOLBM_MUL_SCHED_PRIO0_EN defined, always grant requester 0 when it is valid and a credit is free, and round-robin the others.
REQ-032 SHALL, with STEREOLBM_MUL_SCHED_PRIO0_EN undefined, apply pure round-robin across all NREQ requesters.

Verification
REQ-033 SHALL cover: req0 with a=0xFFFFFFFD (-3), b=2047 -> rsp_data=0xFFFFE803, rsp_tag=0, rsp_valid 3 cycles after the request.
REQ-034 SHALL cover: req2 with a=0x7FFFFFFF, b=2 -> rsp_data=0xFFFFFFFE (truncation), rsp_tag=2.
REQ-035 SHALL cover: all 4 requesters valid continuously after reset -> grants 0,1,2,3,0,... and tags in the same order (macro undefined).
REQ-036 SHALL cover: rsp_ready=0 with requests pending -> exactly 4 grants, then req_ready=0; one rsp_ready pulse -> exactly one new grant.
REQ-037 SHALL cover: ap_rst_n pulsed low 1 cycle after a grant -> no rsp_valid afterwards; next grant goes to requester 0.
REQ-038 SHALL cover: macro defined with req0 and req1 always valid -> req0 granted every cycle while credits are available.

Source files
------------

// File: rtl/stereolbm_mul_sched.sv
// Shared signed-by-unsigned multiplier with round-robin request scheduling, credit flow control and an in-order result FIFO.
// Define STEREOLBM_MUL_SCHED_PRIO0_EN to give requester 0 fixed priority over the others.
module stereolbm_mul_sched #(
    parameter int NREQ       = 4,
    parameter int TAG_W      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*11-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [31:0]          rsp_data,
    output logic                 busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TAG_W:0]   NREQ_C   = (TAG_W + 1)'(NREQ);
    localparam logic [TAG_W-1:0] LAST_RST = TAG_W'(NREQ - 1);

    logic [TAG_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] credits_q, credits_d;
    logic             s1_vld_q, s1_vld_d;
    logic [31:0]      a1_q, a1_d;
    logic [10:0]      b1_q, b1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;
    logic             s2_vld_q, s2_vld_d;
    logic [31:0]      prod2_q, prod2_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      mem_data [FIFO_DEPTH];
    logic [TAG_W-1:0] mem_tag  [FIFO_DEPTH];

    logic             grant_any;
    logic [TAG_W-1:0] grant_idx;
    logic [TAG_W:0]   cand;
    logic             accept;
    logic             pop;

    // Round-robin search from last_grant+1; the fixed-priority build excludes
    // requester 0 from the rotation and lets it override when valid.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = {1'b0, last_q} + (TAG_W + 1)'(off);
            if (cand >= NREQ_C) begin
                cand = cand - NREQ_C;
            end
`ifdef STEREOLBM_MUL_SCHED_PRIO0_EN
            if (!grant_any && (cand != '0) && req_valid[cand[TAG_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[TAG_W-1:0];
            end
`else
            if (!grant_any && req_valid[cand[TAG_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[TAG_W-1:0];
            end
`endif
        end
`ifdef STEREOLBM_MUL_SCHED_PRIO0_EN
        if (req_valid[0]) begin
            grant_any = 1'b1;
            grant_idx = '0;
        end
`endif
        accept    = ap_rst_n && grant_any && (credits_q != DEPTH_C);
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign rsp_valid = (cnt_q != '0);
    assign rsp_tag   = mem_tag[rd_ptr_q];
    assign rsp_data  = mem_data[rd_ptr_q];
    assign busy      = (credits_q != '0);
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        last_d    = accept ? grant_idx : last_q;
        credits_d = credits_q + CNT_W'(accept) - CNT_W'(pop);

        s1_vld_d  = accept;
        a1_d      = accept ? req_a[int'(grant_idx)*32 +: 32] : a1_q;
        b1_d      = accept ? req_b[int'(grant_idx)*11 +: 11] : b1_q;
        tag1_d    = accept ? grant_idx : tag1_q;

        // The low 32 product bits are the same whether a is read as signed or
        // unsigned, so a plain 32-bit multiply by zero-extended b suffices.
        s2_vld_d  = s1_vld_q;
        prod2_d   = a1_q * {21'b0, b1_q};
        tag2_d    = tag1_q;

        wr_ptr_d  = wr_ptr_q + PTR_W'(s2_vld_q);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        cnt_d     = cnt_q + CNT_W'(s2_vld_q) - CNT_W'(pop);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            last_q    <= LAST_RST;
            credits_q <= '0;
            s1_vld_q  <= 1'b0;
            a1_q      <= '0;
            b1_q      <= '0;
            tag1_q    <= '0;
            s2_vld_q  <= 1'b0;
            prod2_q   <= '0;
            tag2_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            last_q    <= last_d;
            credits_q <= credits_d;
            s1_vld_q  <= s1_vld_d;
            a1_q      <= a1_d;
            b1_q      <= b1_d;
            tag1_q    <= tag1_d;
            s2_vld_q  <= s2_vld_d;
            prod2_q   <= prod2_d;
            tag2_q    <= tag2_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Storage only; validity is carried by cnt_q and the pointers.
    always_ff @(posedge ap_clk) begin
        if (s2_vld_q) begin
            mem_data[wr_ptr_q] <= prod2_q;
            mem_tag[wr_ptr_q]  <= tag2_q;
        end
    end

endmodule
